matrix_stream_feeder: RTL and testbench
=======================================

Name: matrix_stream_feeder

Overview:
- Holds one S x S operand matrix of N-bit elements and streams it as an S-lane vector, one column per cycle, into the systolic input-skew delay stage.
- After the S data columns it emits S-1 zero vectors, so the most-delayed skew lane drains fully into the PE array.
- Packed output lane ordering matches the skew stage: lane 0 (zero delay) occupies the MSB chunk.

Parameters:
- N, 2, element width in bits
- S, 4, matrix dimension; also the lane count
- IW, 2, row/column index width; requires 2**IW >= S

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- ld_en  in  1  element write strobe
- ld_row  in  IW  write row index
- ld_col  in  IW  write column index
- ld_data  in  N  element value
- start  in  1  begin streaming request, level-sampled
- busy  out  1  high while streaming or flushing
- out_vld  out  1  out_data carries a valid stream/flush vector
- out_data  out  S*N  lane r at bits [S*N-1-r*N : S*N-N-r*N]
- done  out  1  one-cycle pulse at end of flush

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All S*S memory entries, out_data, out_vld, busy and done are forced to 0.
- States: IDLE, STREAM, FLUSH, DONE. A counter of width IW+1 indexes the current column or flush cycle.
- IDLE:
  - If ld_en=1, mem[ld_row][ld_col] <= ld_data at the clock edge.
  - Writes with ld_row>=S or ld_col>=S are ignored.
  - If start=1 at edge T0: state->STREAM, cnt=0, busy=1.
  - If ld_en and start are both high at T0, the write completes and is visible in the stream.
- STREAM:
  - At edge T1+k, k=0..S-1: out_data lane r = mem[r][k] and out_vld=1. T1 is the edge after T0.
  - After k=S-1, state->FLUSH and cnt resets.
- FLUSH:
  - At edges T1+S .. T1+2S-2: out_data=0 and out_vld=1, giving S-1 cycles.
  - If S=1, FLUSH is skipped.
- DONE:
  - At edge T1+2S-1: out_vld=0, out_data=0, done=1, busy=0.
  - Next edge returns to IDLE with done=0.
- Latency: start to first vector is 1 cycle. The valid window is exactly 2S-1 consecutive cycles. start to done is 2S cycles.
- While busy:
  - ld_en is ignored, so the memory is frozen during a stream.
  - start is ignored. It is not queued.
- start held high through DONE launches the next stream at the edge after the IDLE re-entry. The gap between valid windows is exactly 2 cycles: the DONE cycle and the IDLE cycle.
- Memory contents persist across streams. Only reset clears them.
- Reset asserted mid-stream aborts immediately:
  - All outputs go to 0 and the memory is cleared.
  - No done pulse is generated.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset check, S=4, N=2: assert rst=0 mid-simulation -> busy, out_vld, done=0, out_data=8'h00 asynchronously, before the next clock edge.
- Load mem[r][c]=(r+c)&3 for all 16 entries, then pulse start -> out_data sequence, one per cycle:
  - 8'h1B, 8'h6C, 8'hB1, 8'hC6
  - then 8'h00 for 3 cycles
  - out_vld high 7 cycles, done pulse on cycle 8 after start.
- Out-of-range write: IW=3, S=4, ld_row=5, value 3 -> memory unchanged; the stream after a zero-reset shows all-zero vectors.
- Load attempt and second start during busy, with mem[0][0] rewrite to 2'b11 attempted while busy -> ignored. The next stream shows the original value and done pulses exactly once.
- start held high continuously -> valid windows of 7 cycles separated by exactly 2 invalid cycles, contents identical each time.
- Reset asserted at stream cycle 2 -> outputs 0 immediately, no done. After release, a new start streams all-zero columns.

Source files
------------

// File: rtl/matrix_stream_feeder.sv
// Feeds one S x S operand matrix into the systolic skew stage, one column per cycle,
// followed by S-1 zero vectors so the most-delayed lane drains into the PE array.
module matrix_stream_feeder #(
  parameter int N  = 2,
  parameter int S  = 4,
  parameter int IW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_en,
  input  logic [IW-1:0]  ld_row,
  input  logic [IW-1:0]  ld_col,
  input  logic [N-1:0]   ld_data,
  input  logic           start,
  output logic           busy,
  output logic           out_vld,
  output logic [S*N-1:0] out_data,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

  state_e         state_q, state_d;
  logic [IW:0]    cnt_q, cnt_d;
  logic [N-1:0]   mem_q [S][S];
  logic [S*N-1:0] data_q, data_d;
  logic           vld_q, vld_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (int'(cnt_q) == S - 1) begin
          if (S > 1) state_d = FLUSH;
          else       state_d = DONE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (int'(cnt_q) >= S - 2) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are computed from the current state and registered at the next edge,
  // which gives the one-cycle start-to-first-vector latency.
  always_comb begin
    data_d = '0;
    vld_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: busy_d = start;
      STREAM: begin
        busy_d = 1'b1;
        vld_d  = 1'b1;
        for (int r = 0; r < S; r++) begin
          for (int c = 0; c < S; c++) begin
            if (int'(cnt_q) == c) data_d[S*N-1-r*N -: N] = mem_q[r][c];
          end
        end
      end
      FLUSH: begin
        busy_d = 1'b1;
        vld_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Writes land only while idle; indices outside the matrix match no entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (state_q == IDLE && ld_en) begin
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S; c++) begin
          if (int'(ld_row) == r && int'(ld_col) == c) mem_q[r][c] <= ld_data;
        end
      end
    end
  end

  assign out_data = data_q;
  assign out_vld  = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Randomized bench for matrix_stream_feeder against a matrix-level reference model.
module tb_matrix_stream_feeder;
  localparam int N  = 2;
  localparam int S  = 4;
  localparam int IW = 3;

  logic           clk;
  logic           rst;
  logic           ld_en;
  logic [IW-1:0]  ld_row;
  logic [IW-1:0]  ld_col;
  logic [N-1:0]   ld_data;
  logic           start;
  logic           busy;
  logic           out_vld;
  logic [S*N-1:0] out_data;
  logic           done;

  int checks = 0;
  int errors = 0;
  int model [S][S];

  matrix_stream_feeder #(.N(N), .S(S), .IW(IW)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_row(ld_row), .ld_col(ld_col),
    .ld_data(ld_data), .start(start), .busy(busy), .out_vld(out_vld),
    .out_data(out_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Column k as a base-2**N number whose most significant digit is row 0.
  function automatic logic [S*N-1:0] exp_col(input int k);
    int acc = 0;
    for (int r = 0; r < S; r++) acc = acc * (1 << N) + model[r][k];
    return acc[S*N-1:0];
  endfunction

  task automatic clear_model();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) model[r][c] = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_vld"}, out_vld, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_zero_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  task automatic load(input int r, input int c, input int d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_row  = r[IW-1:0];
    ld_col  = c[IW-1:0];
    ld_data = d[N-1:0];
    if (r < S && c < S) model[r][c] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_stream(input bit with_ld, input int lr, input int lc, input int ld,
                            input bit poke, input bit lit);
    int done_cnt = 0;
    logic [7:0] lit_tab [4] = '{8'h1B, 8'h6C, 8'hB1, 8'hC6};
    @(negedge clk);
    start = 1'b1;
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_row  = lr[IW-1:0];
      ld_col  = lc[IW-1:0];
      ld_data = ld[N-1:0];
      if (lr < S && lc < S) model[lr][lc] = ld;
    end
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    check("launch_busy", busy, 1);
    check("launch_vld", out_vld, 0);
    for (int k = 0; k < 2*S; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      check("vld", out_vld, (k < 2*S-1) ? 1 : 0);
      check("busy", busy, (k < 2*S-1) ? 1 : 0);
      check("done", done, (k == 2*S-1) ? 1 : 0);
      check("data", out_data, (k < S) ? exp_col(k) : '0);
      if (lit && k < S) check("lit_col", out_data, lit_tab[k]);
      if (poke && k == 1) begin
        ld_en = 1'b1; ld_row = '0; ld_col = '0; ld_data = 2'b11; start = 1'b1;
      end else begin
        ld_en = 1'b0; start = 1'b0;
      end
    end
    @(negedge clk);
    if (done) done_cnt++;
    check_zero_outputs("after");
    check("done_once", done_cnt, 1);
  endtask

  task automatic hold_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("hold_launch_busy", busy, 1);
    check("hold_launch_vld", out_vld, 0);
    for (int j = 1; j <= 2*(2*S+1); j++) begin
      int p;
      @(negedge clk);
      p = (j - 1) % (2*S+1);
      check("hold_vld", out_vld, (p < 2*S-1) ? 1 : 0);
      check("hold_done", done, (p == 2*S-1) ? 1 : 0);
      check("hold_busy", busy, (p != 2*S-1) ? 1 : 0);
      check("hold_data", out_data, (p < S) ? exp_col(p) : '0);
    end
    start = 1'b0;
    repeat (2*S+2) @(negedge clk);
    check_zero_outputs("hold_end");
  endtask

  task automatic reset_mid_stream();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_vld", out_vld, 1);
    #2 rst = 1'b0;
    #1 check_zero_outputs("mid_rst");
    clear_model();
    repeat (2) @(negedge clk);
    check("mid_rst_done", done, 0);
    rst = 1'b1;
    repeat (2*S+2) @(negedge clk);
    check("mid_no_done", done, 0);
    check("mid_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_en = 1'b0;
    ld_row = '0; ld_col = '0; ld_data = '0;
    clear_model();
    #1 rst = 1'b0;
    #1 check_zero_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) load(r, c, (r + c) & 3);
    run_stream(0, 0, 0, 0, 0, 1);

    do_reset();
    load(5, 1, 3);
    load(1, 6, 3);
    load(7, 7, 3);
    run_stream(0, 0, 0, 0, 0, 0);

    repeat (24) load($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
    run_stream(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);

    load(0, 0, 1);
    run_stream(0, 0, 0, 0, 1, 0);
    run_stream(0, 0, 0, 0, 0, 0);

    hold_start();

    reset_mid_stream();
    run_stream(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
